// File: rtl/pc_sequencer_if.sv
// Control-side bundle for pc_sequencer: load/source select and targets in, PC state and RAS status out.
interface pc_sequencer_if #(
  parameter int ADDR_W    = 32,
  parameter int RAS_DEPTH = 4
);
  localparam int CNT_W = $clog2(RAS_DEPTH) + 1;

  logic              load;
  logic [1:0]        src;
  logic              taken;
  logic [ADDR_W-1:0] offset;
  logic [ADDR_W-1:0] target;
  logic              call;
  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] npc;
  logic [CNT_W-1:0]  ras_count;
  logic              ras_ovf;
  logic              ras_unf;
  logic              misalign;
  logic [ADDR_W-1:0] bad_addr;

  modport master (
    output load, src, taken, offset, target, call,
    input  pc, npc, ras_count, ras_ovf, ras_unf, misalign, bad_addr
  );

  modport slave (
    input  load, src, taken, offset, target, call,
    output pc, npc, ras_count, ras_ovf, ras_unf, misalign, bad_addr
  );
endinterface

// File: rtl/pc_sequencer.sv
// PC/NPC sequencer with seq/branch/jump/return selection and a circular return-address stack.
// Optional target alignment rejection is enabled by defining PC_ALIGN_CHECK_EN.
module pc_sequencer #(
  parameter int                ADDR_W    = 32,
  parameter logic [ADDR_W-1:0] RESET_VEC = '0,
  parameter int                INC_SHIFT = 2,
  parameter int                RAS_DEPTH = 4
) (
  input logic          clk,
  input logic          reset,
  pc_sequencer_if.slave bus
);
  localparam int PTR_W = $clog2(RAS_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [ADDR_W-1:0] INC = {{(ADDR_W-1){1'b0}}, 1'b1} << INC_SHIFT;

  logic [ADDR_W-1:0] pc_q;
  logic [ADDR_W-1:0] npc_q;
  logic [ADDR_W-1:0] ras_mem [RAS_DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [CNT_W-1:0]  count;
  logic              ovf_q;
  logic              unf_q;

  logic [PTR_W-1:0]  top_ptr;
  logic              ras_empty;
  logic              ras_full;
  logic [ADDR_W-1:0] nxt;
  logic              do_push;
  logic              do_pop;
  logic              pop_unf;
  logic              bad_align;

  assign top_ptr   = wr_ptr - 1'b1;
  assign ras_empty = (count == '0);
  assign ras_full  = (count == CNT_W'(RAS_DEPTH));

  always_comb begin
    nxt     = npc_q;
    do_push = 1'b0;
    do_pop  = 1'b0;
    pop_unf = 1'b0;
    case (bus.src)
      2'b00: nxt = npc_q;
      2'b01: nxt = bus.taken ? (npc_q + (bus.offset << INC_SHIFT)) : npc_q;
      2'b10: begin
        nxt     = bus.target;
        do_push = bus.call;
      end
      default: begin
        if (ras_empty) begin
          pop_unf = 1'b1;
        end else begin
          nxt    = ras_mem[top_ptr];
          do_pop = 1'b1;
        end
      end
    endcase
  end

  // A rejected target still consumes a popped entry; only the PC update and push are blocked.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_q   <= RESET_VEC;
      npc_q  <= RESET_VEC + INC;
      wr_ptr <= '0;
      count  <= '0;
      ovf_q  <= 1'b0;
      unf_q  <= 1'b0;
    end else begin
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
      if (bus.load) begin
        unf_q <= pop_unf;
        if (do_pop) begin
          wr_ptr <= top_ptr;
          count  <= count - 1'b1;
        end
        if (!bad_align) begin
          pc_q  <= nxt;
          npc_q <= nxt + INC;
          if (do_push) begin
            wr_ptr <= wr_ptr + 1'b1;
            if (ras_full) ovf_q <= 1'b1;
            else          count <= count + 1'b1;
          end
        end
      end
    end
  end

  // When full, wr_ptr already points at the oldest entry, so a push overwrites it.
  always_ff @(posedge clk) begin
    if (bus.load && do_push && !bad_align) ras_mem[wr_ptr] <= npc_q;
  end

`ifdef PC_ALIGN_CHECK_EN
  logic              mis_q;
  logic [ADDR_W-1:0] bad_q;

  assign bad_align = ((nxt & (INC - 1'b1)) != '0);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mis_q <= 1'b0;
      bad_q <= '0;
    end else begin
      mis_q <= bus.load & bad_align;
      if (bus.load && bad_align) bad_q <= nxt;
    end
  end

  assign bus.misalign = mis_q;
  assign bus.bad_addr = bad_q;
`else
  assign bad_align    = 1'b0;
  assign bus.misalign = 1'b0;
  assign bus.bad_addr = '0;
`endif

  assign bus.pc        = pc_q;
  assign bus.npc       = npc_q;
  assign bus.ras_count = count;
  assign bus.ras_ovf   = ovf_q;
  assign bus.ras_unf   = unf_q;
endmodule

// File: tb/tb_pc_sequencer.sv
// Scoreboard bench for pc_sequencer: a queue-based reference model predicts every cycle's outputs.
module tb_pc_sequencer;
  localparam int          ADDR_W    = 32;
  localparam int          INC_SHIFT = 2;
  localparam int          RAS_DEPTH = 4;
  localparam logic [31:0] RESET_VEC = 32'h0;
  localparam logic [31:0] INC       = 32'd4;
`ifdef PC_ALIGN_CHECK_EN
  localparam bit ALIGN = 1'b1;
`else
  localparam bit ALIGN = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  pc_sequencer_if #(.ADDR_W(ADDR_W), .RAS_DEPTH(RAS_DEPTH)) bus ();

  pc_sequencer #(
    .ADDR_W(ADDR_W), .RESET_VEC(RESET_VEC), .INC_SHIFT(INC_SHIFT), .RAS_DEPTH(RAS_DEPTH)
  ) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  typedef struct {
    int unsigned due;
    logic [31:0] pc, npc, bad;
    int          cnt;
    bit          ovf, unf, mis;
    string       tag;
  } exp_t;

  exp_t        sbq[$];
  logic [31:0] m_pc, m_npc, m_bad;
  logic [31:0] m_ras[$];
  int unsigned cyc = 0;
  int          n_checks = 0;
  int          n_fail = 0;

  always @(posedge clk) cyc = cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  task automatic model_reset();
    m_pc  = RESET_VEC;
    m_npc = RESET_VEC + INC;
    m_bad = '0;
    m_ras.delete();
  endtask

  // Drive one cycle of stimulus and queue the outputs the model predicts after the next edge.
  task automatic step(input bit ld, input logic [1:0] s, input bit tk, input logic [31:0] off,
                      input logic [31:0] tgt, input bit cl, input string tag);
    exp_t        e;
    logic [31:0] nxt;
    bit          push;
    @(posedge clk);
    #1;
    bus.load = ld; bus.src = s; bus.taken = tk; bus.offset = off; bus.target = tgt; bus.call = cl;
    e.ovf = 0; e.unf = 0; e.mis = 0; push = 0; nxt = m_npc;
    if (ld) begin
      case (s)
        2'b00: nxt = m_npc;
        2'b01: nxt = tk ? m_npc + (off << INC_SHIFT) : m_npc;
        2'b10: begin nxt = tgt; push = cl; end
        default: begin
          if (m_ras.size() == 0) begin nxt = m_npc; e.unf = 1; end
          else nxt = m_ras.pop_back();
        end
      endcase
      if (ALIGN && ((nxt & (INC - 1)) != 0)) begin
        e.mis = 1;
        m_bad = nxt;
      end else begin
        if (push) begin
          m_ras.push_back(m_npc);
          if (m_ras.size() > RAS_DEPTH) begin
            void'(m_ras.pop_front());
            e.ovf = 1;
          end
        end
        m_pc  = nxt;
        m_npc = nxt + INC;
      end
    end
    e.due = cyc + 1; e.pc = m_pc; e.npc = m_npc; e.cnt = m_ras.size(); e.bad = m_bad; e.tag = tag;
    sbq.push_back(e);
  endtask

  task automatic idle();
    step(0, 2'b00, 0, '0, '0, 0, "idle");
  endtask

  task automatic drain();
    idle();
    for (int i = 0; i < 20 && sbq.size() > 0; i++) begin
      @(negedge clk);
      #1;
    end
    n_checks++;
    if (sbq.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d entries left, expected 0", sbq.size());
      sbq.delete();
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      while (sbq.size() > 0 && sbq[0].due <= cyc) begin
        e = sbq.pop_front();
        chk({e.tag, ".pc"},        bus.pc,                e.pc);
        chk({e.tag, ".npc"},       bus.npc,               e.npc);
        chk({e.tag, ".ras_count"}, 32'(bus.ras_count),    32'(e.cnt));
        chk({e.tag, ".flags"},     {29'd0, bus.ras_ovf, bus.ras_unf, bus.misalign},
                                   {29'd0, e.ovf, e.unf, e.mis});
        chk({e.tag, ".bad_addr"},  bus.bad_addr,          e.bad);
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : stim
    logic [31:0] tgt, off;
    bus.load = 0; bus.src = 2'b00; bus.taken = 0; bus.offset = '0; bus.target = '0; bus.call = 0;
    model_reset();
    #12;
    chk("rst.pc",        bus.pc,             RESET_VEC);
    chk("rst.npc",       bus.npc,            RESET_VEC + INC);
    chk("rst.ras_count", 32'(bus.ras_count), 32'd0);
    chk("rst.flags",     {29'd0, bus.ras_ovf, bus.ras_unf, bus.misalign}, 32'd0);
    chk("rst.bad_addr",  bus.bad_addr,       32'd0);
    @(negedge clk);
    reset = 1;

    for (int i = 0; i < 3; i++) step(1, 2'b00, 0, '0, '0, 0, "seq");
    drain();
    chk("seq3.pc", bus.pc, 32'h0C);
    chk("seq3.npc", bus.npc, 32'h10);

    step(1, 2'b10, 0, '0, 32'h100, 0, "jmp100");
    step(1, 2'b01, 1, 32'hFFFF_FFFE, '0, 0, "br_taken");
    drain();
    chk("br_taken.pc", bus.pc, 32'h0FC);
    chk("br_taken.npc", bus.npc, 32'h100);
    step(1, 2'b10, 0, '0, 32'h100, 0, "jmp100b");
    step(1, 2'b01, 0, 32'hFFFF_FFFE, '0, 0, "br_not");
    drain();
    chk("br_not.pc", bus.pc, 32'h104);

    step(1, 2'b10, 0, '0, 32'h20, 0, "jmp20");
    step(1, 2'b10, 0, '0, 32'h400, 1, "call400");
    step(1, 2'b11, 0, '0, '0, 0, "ret1");
    step(1, 2'b11, 0, '0, '0, 0, "ret_empty");
    drain();
    chk("ret_empty.pc", bus.pc, 32'h28);

    step(1, 2'b10, 0, '0, 32'h1000, 0, "jmp1000");
    for (int i = 1; i <= 5; i++) step(1, 2'b10, 0, '0, 32'h1000 + 32'(i) * 32'h100, 1, "nest_call");
    for (int i = 0; i < 5; i++) step(1, 2'b11, 0, '0, '0, 0, "nest_ret");
    drain();
    chk("nest_ret.pc", bus.pc, 32'h1108);

    step(1, 2'b10, 0, '0, 32'hFFFF_FFFC, 0, "jmp_top");
    step(1, 2'b00, 0, '0, '0, 0, "wrap");
    drain();
    chk("wrap.pc", bus.pc, 32'h0);

    step(1, 2'b10, 0, '0, 32'h200, 0, "jmp200");
    step(1, 2'b10, 0, '0, 32'h402, 1, "jmp402");
    drain();
    chk("jmp402.pc", bus.pc, ALIGN ? 32'h200 : 32'h402);
    step(1, 2'b10, 0, '0, 32'h300, 0, "realign");

    for (int i = 0; i < 400; i++) begin
      tgt = {14'd0, 16'($urandom_range(0, 16'hFFFF)), 2'b00};
      if ($urandom_range(0, 7) == 0) tgt[1:0] = 2'($urandom_range(1, 3));
      off = 32'($urandom_range(0, 64)) - 32'd32;
      step($urandom_range(0, 9) != 0, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
           off, tgt, 1'($urandom_range(0, 1)), "rand");
    end
    drain();

    // Reset dropped mid-cycle while a load is pending must clear without a clock edge.
    @(posedge clk);
    #1;
    bus.load = 1; bus.src = 2'b00;
    #2;
    reset = 0;
    #1;
    chk("arst.pc",        bus.pc,             RESET_VEC);
    chk("arst.npc",       bus.npc,            RESET_VEC + INC);
    chk("arst.ras_count", 32'(bus.ras_count), 32'd0);
    bus.load = 0;
    model_reset();
    repeat (2) @(negedge clk);
    reset = 1;
    step(1, 2'b00, 0, '0, '0, 0, "post_rst_seq");
    drain();
    chk("post_rst.pc", bus.pc, RESET_VEC + INC);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
- Parametrised successor to the single-register program counter.
- Holds PC and NPC and selects the next fetch address: sequential, PC-relative branch, absolute jump, or return.
- Keeps an internal return-address stack (RAS) for call/return.
- Driven by the multicycle control FSM: pcLoad maps to load, npcLoad/branch/jump map to src; sits between the control unit and the MAR mux.

Parameters:
- ADDR_W, 32: width of PC, NPC, target and offset.
- RESET_VEC, 0: PC value after reset.
- INC_SHIFT, 2: log2 of the instruction size in bytes; INC = 1<<INC_SHIFT.
- RAS_DEPTH, 4: return-stack entries; power of two, ≥2.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- load  in  1  update PC/NPC at this edge.
- src  in  2  next-PC source: 00 seq, 01 branch, 10 jump, 11 return.
- taken  in  1  branch condition; used only when src=01.
- offset  in  ADDR_W  sign-extended word offset for branch.
- target  in  ADDR_W  absolute jump address, in bytes.
- call  in  1  with src=10, push NPC onto the RAS.
- pc  out  ADDR_W  current PC.
- npc  out  ADDR_W  registered PC+INC.
- ras_count  out  clog2(RAS_DEPTH)+1  valid RAS entries.
- ras_ovf  out  1  one-cycle pulse: push while full.
- ras_unf  out  1  one-cycle pulse: pop while empty.
- misalign  out  1  one-cycle pulse: rejected target (see Optional Feature).
- bad_addr  out  ADDR_W  last rejected address.

Behaviour:
- Reset (asynchronous, reset=0), all outputs:
  - pc = RESET_VEC; npc = RESET_VEC + INC.
  - ras_count = 0; ras_ovf = ras_unf = misalign = 0; bad_addr = 0.
  - RAS contents don't-care.
- load=0: all state holds; pulse outputs are 0.
- load=1, next address nxt:
  - src 00: nxt = npc.
  - src 01: nxt = npc + (offset << INC_SHIFT) if taken, else npc.
  - src 10: nxt = target.
  - src 11: nxt = RAS top and pop. If RAS is empty: nxt = npc, ras_count stays 0, ras_unf pulses.
- Latency: at the load edge, pc <= nxt and npc <= nxt + INC; the new values are visible one cycle after load.
- Arithmetic: all modulo 2^ADDR_W, so wrap-around is silent (e.g. pc = all ones-3 with seq gives 0).
- Call (load & src=10 & call): push the pre-update npc (the return address).
  - If RAS is full: overwrite the oldest entry (circular buffer), ras_count stays RAS_DEPTH, ras_ovf pulses.
- call is ignored when src≠10.
- Push and pop cannot coincide, because src encodes them exclusively.
- Back-to-back loads on consecutive cycles are legal; each uses the registered npc from the previous edge.
- Reset asserted mid-sequence clears immediately, independent of clk; the first load after release uses RESET_VEC-based values.

Optional Feature:
- Macro: PC_ALIGN_CHECK_EN.
- Defined:
  - If load=1 and nxt[INC_SHIFT-1:0]≠0, pc/npc/RAS hold unchanged (a call push is also suppressed).
  - misalign pulses one cycle and bad_addr <= nxt.
  - A misaligned RAS pop still consumes the entry.
- Undefined:
  - nxt is loaded as-is; misalign is tied 0 and bad_addr stays 0.

Test Plan:
- Reset then 3 seq loads, RESET_VEC=0 -> pc 4, 8, 12; npc 8, 12, 16.
- Branch: pc=0x100 (npc=0x104), offset=-2, taken=1 -> pc=0x0FC, npc=0x100. Same stimulus with taken=0 -> pc=0x104.
- Call/return:
  - jump target=0x400 with call from pc=0x20 -> pc=0x400, ras_count=1.
  - src=11 -> pc=0x24, ras_count=0.
  - Second src=11 -> pc=0x28, ras_unf pulse.
- Overflow, RAS_DEPTH=4: five nested calls -> ras_ovf on 5th; five returns yield the last four return addresses in LIFO order, then ras_unf on the 5th.
- Async reset: drop reset mid-cycle during a load -> pc=RESET_VEC without a clk edge, ras_count=0.
- With PC_ALIGN_CHECK_EN, jump target=0x402 -> pc unchanged, misalign=1 for 1 cycle, bad_addr=0x402. Without the macro -> pc=0x402.
